// File: rtl/yontem1.sv
// Registered 64-bit unsigned adder built from 4-bit carry-lookahead groups with rippled group carries.
// Optional registered carry-out is enabled by defining YONTEM1_CARRY_OUT_EN.
module yontem1 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  output logic [WIDTH-1:0] sum_o,
`ifdef YONTEM1_CARRY_OUT_EN
  output logic             carry_o,
`endif
  output logic             valid_o
);

  localparam int unsigned NumGroups = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [3:0]       w_grp_g;
  logic [3:0]       w_grp_p;
  logic [3:0]       w_grp_c;

  logic [WIDTH-1:0] r_sum;
  logic             r_valid;

  assign w_g = num1_i & num2_i;
  assign w_p = num1_i ^ num2_i;

  // Lookahead inside each group; w_carry walks the group boundaries and ends as the carry-out.
  always_comb begin
    w_sum   = '0;
    w_carry = 1'b0;
    w_grp_g = '0;
    w_grp_p = '0;
    w_grp_c = '0;
    for (int k = 0; k < NumGroups; k++) begin
      w_grp_g    = w_g[4*k +: 4];
      w_grp_p    = w_p[4*k +: 4];
      w_grp_c[0] = w_carry;
      w_grp_c[1] = w_grp_g[0] | (w_grp_p[0] & w_carry);
      w_grp_c[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0]) | (&w_grp_p[1:0] & w_carry);
      w_grp_c[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1]) | (&w_grp_p[2:1] & w_grp_g[0])
                 | (&w_grp_p[2:0] & w_carry);
      w_sum[4*k +: 4] = w_grp_p ^ w_grp_c;
      w_carry = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2]) | (&w_grp_p[3:2] & w_grp_g[1])
              | (&w_grp_p[3:1] & w_grp_g[0]) | (&w_grp_p & w_carry);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sum   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sum <= w_sum;
      end
    end
  end

`ifdef YONTEM1_CARRY_OUT_EN
  logic r_carry;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_carry <= 1'b0;
    end else if (valid_i) begin
      r_carry <= w_carry;
    end
  end

  assign carry_o = r_carry;
`else
  // Carry-out is dropped when the port is configured out.
  logic w_unused_carry;
  assign w_unused_carry = w_carry;
`endif

  assign sum_o   = r_sum;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_yontem1.sv
// Scoreboard bench for yontem1: stimulus pushes model expectations, a monitor pops and compares.
module tb_yontem1;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [63:0] num1_i;
  logic [63:0] num2_i;
  logic [63:0] sum_o;
  logic        valid_o;
  logic        carry_o;

  typedef struct {
    logic        v;
    logic [63:0] s;
    logic        c;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  logic [63:0] m_sum   = '0;
  logic        m_carry = 1'b0;

  always #5 clk_i = ~clk_i;

  yontem1 #(.WIDTH(64)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .num1_i  (num1_i),
    .num2_i  (num2_i),
    .sum_o   (sum_o),
`ifdef YONTEM1_CARRY_OUT_EN
    .carry_o (carry_o),
`endif
    .valid_o (valid_o)
  );

`ifndef YONTEM1_CARRY_OUT_EN
  assign carry_o = 1'b0;
`endif

  // Drive one cycle of inputs (called just after a falling edge) and queue the
  // output expected after the following rising edge.
  task automatic step(input logic rst, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input string name);
    logic [64:0] full;
    exp_t        e;
    rst_i   = rst;
    valid_i = v;
    num1_i  = a;
    num2_i  = b;
    full = {1'b0, a} + {1'b0, b};
    if (rst) begin
      m_sum   = '0;
      m_carry = 1'b0;
      e.v     = 1'b0;
    end else begin
      e.v = v;
      if (v) begin
        m_sum   = full[63:0];
        m_carry = full[64];
      end
    end
    e.s    = m_sum;
    e.c    = m_carry;
    e.name = name;
    q.push_back(e);
    @(negedge clk_i);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (valid_o !== e.v) begin
          errors++;
          $display("FAIL %s valid_o: got %b expected %b", e.name, valid_o, e.v);
        end
        checks++;
        if (sum_o !== e.s) begin
          errors++;
          $display("FAIL %s sum_o: got %h expected %h", e.name, sum_o, e.s);
        end
`ifdef YONTEM1_CARRY_OUT_EN
        checks++;
        if (carry_o !== e.c) begin
          errors++;
          $display("FAIL %s carry_o: got %b expected %b", e.name, carry_o, e.c);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    int          wait_cycles;
    logic [63:0] a;
    logic [63:0] b;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    num1_i  = '0;
    num2_i  = '0;
    @(negedge clk_i);

    step(1'b1, 1'b1, 64'd10, 64'd20, "reset_discard");
    step(1'b1, 1'b0, 64'd0, 64'd0, "reset_idle");
    step(1'b0, 1'b1, 64'd1, 64'd1, "one_plus_one");
    step(1'b0, 1'b0, 64'd5, 64'd6, "hold_invalid");
    step(1'b0, 1'b0, 64'd7, 64'd9, "hold_invalid2");
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "wrap_all_ones");
    step(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "wrap_msb");
    step(1'b0, 1'b1, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAB, "alt_carry_chain");
    step(1'b0, 1'b1, 64'd205379, 64'd389017, "sweep_example");
    step(1'b0, 1'b0, 64'd3, 64'd4, "hold_after_carry");
    step(1'b1, 1'b1, 64'd10, 64'd20, "reset_mid");
    step(1'b0, 1'b1, 64'd10, 64'd20, "after_reset");
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "max_plus_max");

    // Back-to-back small operands from the sweep ranges.
    for (int i = 0; i < 200; i++) begin
      a = 64'($urandom_range(205379, 1));
      b = 64'($urandom_range(389017, 1));
      step(1'b0, 1'b1, a, b, "sweep_rand");
    end

    // Full-width random operands with sporadic idle cycles and resets.
    for (int i = 0; i < 400; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ((i % 7) == 3) b = ~a + 64'(i % 2);
      step(($urandom_range(39, 0) == 0), ($urandom_range(3, 0) != 0), a, b, "random64");
    end

    step(1'b0, 1'b0, 64'd0, 64'd0, "drain");
    stim_done = 1'b1;

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk_i);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yontem1.md
YONTEM1 -- requirements
Module: yontem1

Interface
- REQ-001: Parameter WIDTH, default 64, operand and sum width in bits; only 64 is required to be supported.
- REQ-002: clk_i, input, 1 bit, single clock; all state updates on its rising edge.
- REQ-003: rst_i, input, 1 bit, reset, synchronous and active-high.
- REQ-004: valid_i, input, 1 bit, qualifies num1_i/num2_i in the current cycle.
- REQ-005: num1_i, input, 64 bits, unsigned addend A.
- REQ-006: num2_i, input, 64 bits, unsigned addend B.
- REQ-007: sum_o, output, 64 bits, registered sum (A+B) mod 2^64.
- REQ-008: valid_o, output, 1 bit, high when sum_o holds a result from a qualified input.
- REQ-009: carry_o, output, 1 bit, registered carry-out of the addition; present only when YONTEM1_CARRY_OUT_EN is defined.

Function
- REQ-010: Combinational core SHALL compute the full 65-bit unsigned sum of num1_i and num2_i.
- REQ-011: Core SHALL be structured as 16 4-bit carry-lookahead groups (generate/propagate per bit, group carry per group), with carries rippled between groups; a behavioral "+" is not permitted for the core.
- REQ-012: When valid_i=1 on a rising edge (rst_i=0), sum_o SHALL load bits [63:0] of the sum (and carry_o, if enabled, SHALL load bit 64); latency exactly 1 cycle.
- REQ-013: When valid_i=0 on a rising edge (rst_i=0), sum_o (and carry_o, if enabled) SHALL hold their previous value.
- REQ-014: valid_o SHALL equal valid_i registered by one cycle.
- REQ-015: Overflow SHALL wrap: result is modulo 2^64, no saturation, no error flag.
- REQ-016: Back-to-back valid inputs SHALL be accepted every cycle (throughput 1 per cycle, no stall, no backpressure).
- REQ-017: Result SHALL depend only on operands sampled on the same edge; no accumulation across cycles.

Reset
- REQ-018: While rst_i=1 on a rising edge, sum_o SHALL become 0, valid_o 0, carry_o (if enabled) 0, regardless of valid_i.
- REQ-019: An operand presented on the same edge that rst_i is asserted SHALL be discarded; reset takes priority.
- REQ-020: The first edge with rst_i=0 and valid_i=1 SHALL produce a normal result one cycle later.

Configuration
- REQ-021: Macro YONTEM1_CARRY_OUT_EN: when defined, port carry_o and its register SHALL exist and follow REQ-012/013/018; when undefined, carry_o SHALL be absent and bit 64 of the sum discarded, with all other behaviour identical.

Verification
- REQ-022: A=1, B=1, valid_i=1 -> next cycle sum_o=2, valid_o=1, carry_o=0.
- REQ-023: Sweep A=59^k (1..205379), B=73^m (1..389017), one pair per cycle, valid_i=1 -> each result equals A+B one cycle later (e.g. 205379+389017 -> 594396); zero mismatches.
- REQ-024: A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> sum_o=0, carry_o=1 (macro defined); A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000 -> sum_o=0, carry_o=1.
- REQ-025: After result 2 is loaded, drive valid_i=0 with A=5, B=6 -> sum_o stays 2, valid_o=0.
- REQ-026: Assert rst_i with valid_i=1, A=10, B=20 -> next cycle sum_o=0, valid_o=0; deassert and reapply -> sum_o=30.
- REQ-027: Alternating-carry check: A=0x5555_5555_5555_5555, B=0xAAAA_AAAA_AAAA_AAAB -> sum_o=0, carry_o=1, exercising full carry chain across all 16 groups.
